// File: rtl/snn_ctrl_pkg.sv
// Shared types for the SNN inference sequencer.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/snn_spike_accum.sv
// Saturating per-output spike counters with next-value view, arg-max and saturation flag.
module snn_spike_accum #(
  parameter int NUM_OUTPUTS = 1,
  parameter int COUNT_WIDTH = 8,
  parameter int WIN_W       = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               en,
  input  logic [NUM_OUTPUTS-1:0]             spikes,
  output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] count_nxt,
  output logic [WIN_W-1:0]                   winner_nxt,
  output logic                               sat_nxt
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] acc_q;
  logic                               sat_q;
  logic [COUNT_WIDTH-1:0]             cur;
  logic [COUNT_WIDTH-1:0]             cnt;
  logic [COUNT_WIDTH-1:0]             best;
  logic                               hit;

  // The next values are exported so results can be latched on the same edge
  // that absorbs the final accumulating cycle.
  always_comb begin
    count_nxt = '0;
    cur       = '0;
    cnt       = '0;
    hit       = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      cur = acc_q[i*COUNT_WIDTH +: COUNT_WIDTH];
      if (clr)
        cnt = '0;
      else if (en && spikes[i] && (cur != CNT_MAX))
        cnt = cur + 1'b1;
      else
        cnt = cur;
      count_nxt[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
      if (cnt == CNT_MAX) hit = 1'b1;
    end
    sat_nxt = clr ? 1'b0 : (sat_q | hit);
  end

  always_comb begin
    best       = count_nxt[COUNT_WIDTH-1:0];
    winner_nxt = '0;
    for (int i = 1; i < NUM_OUTPUTS; i++) begin
      if (count_nxt[i*COUNT_WIDTH +: COUNT_WIDTH] > best) begin
        best       = count_nxt[i*COUNT_WIDTH +: COUNT_WIDTH];
        winner_nxt = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= count_nxt;
      sat_q <= sat_nxt;
    end
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Sequences one SNN inference: clear network, drive spike pattern, drain, latch results.
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | net_clr held, accumulators zeroed
//   RUN   | spike_en = pattern_q for steps_q cycles
//   DRAIN | spike_en low, in-flight spikes still counted
//   DONE  | one-cycle done pulse, results latched
module snn_inference_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_OUTPUTS  = 1,
  parameter int COUNT_WIDTH  = 8,
  parameter int STEP_WIDTH   = 16,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4,
  localparam int WIN_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic                               start,
  input  logic                               abort,
  input  logic [STEP_WIDTH-1:0]              num_steps,
  input  logic [NUM_INPUTS-1:0]              pattern,
  input  logic [NUM_OUTPUTS-1:0]             spike_out,
  output logic [NUM_INPUTS-1:0]              spike_en,
  output logic                               net_clr,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] spike_count,
  output logic [WIN_W-1:0]                   winner,
  output logic                               saturated
);

  localparam logic [STEP_WIDTH-1:0] CLR_LD   = STEP_WIDTH'(CLEAR_CYCLES - 1);
  localparam logic [STEP_WIDTH-1:0] DRAIN_LD = STEP_WIDTH'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t                             state_q, state_nxt;
  logic [STEP_WIDTH-1:0]              phase_q, phase_nxt;
  logic [STEP_WIDTH-1:0]              steps_q;
  logic [NUM_INPUTS-1:0]              pattern_q;
  logic                               accept;
  logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] count_nxt;
  logic [WIN_W-1:0]                   winner_nxt;
  logic                               sat_nxt;

  snn_spike_accum #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .COUNT_WIDTH (COUNT_WIDTH),
    .WIN_W       (WIN_W)
  ) u_accum (
    .clk        (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETN),
    .clr        (state_q == CLEAR),
    .en         ((state_q == RUN) || (state_q == DRAIN)),
    .spikes     (spike_out),
    .count_nxt  (count_nxt),
    .winner_nxt (winner_nxt),
    .sat_nxt    (sat_nxt)
  );

  // phase_q is a single down-counter reloaded on every phase entry; 0 = last cycle.
  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = CLEAR;
          phase_nxt = CLR_LD;
          accept    = 1'b1;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (phase_q != '0) begin
          phase_nxt = phase_q - 1'b1;
        end else if (steps_q != '0) begin
          state_nxt = RUN;
          phase_nxt = steps_q - 1'b1;
        end else if (DRAIN_CYCLES > 0) begin
          state_nxt = DRAIN;
          phase_nxt = DRAIN_LD;
        end else begin
          state_nxt = DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (phase_q != '0) begin
          phase_nxt = phase_q - 1'b1;
        end else if (DRAIN_CYCLES > 0) begin
          state_nxt = DRAIN;
          phase_nxt = DRAIN_LD;
        end else begin
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (phase_q != '0) begin
          phase_nxt = phase_q - 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from state_nxt so they line up with the state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      steps_q     <= '0;
      pattern_q   <= '0;
      spike_en    <= '0;
      net_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_count <= '0;
      winner      <= '0;
      saturated   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      if (accept) begin
        steps_q   <= num_steps;
        pattern_q <= pattern;
      end
      spike_en <= (state_nxt == RUN) ? pattern_q : '0;
      net_clr  <= (state_nxt == CLEAR);
      busy     <= (state_nxt == CLEAR) || (state_nxt == RUN) || (state_nxt == DRAIN);
      done     <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        spike_count <= count_nxt;
        winner      <= winner_nxt;
        saturated   <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Randomized bench for snn_inference_ctrl against a cycle-window reference model.
module tb_snn_inference_ctrl;

  localparam int NI = 4;
  localparam int NO = 3;
  localparam int CW = 8;
  localparam int SW = 16;
  localparam int C  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic [NI-1:0] pattern = '0;
  logic [NO-1:0] spike_out = '0;

  logic [NI-1:0]    spike_en;
  logic             net_clr;
  logic             busy;
  logic             done;
  logic [NO*CW-1:0] spike_count;
  logic [1:0]       winner;
  logic             saturated;

  int checks = 0;
  int errors = 0;

  logic [NO*CW-1:0] exp_cnt = '0;
  logic [1:0]       exp_win = '0;
  logic             exp_sat = 1'b0;
  int               tgt[NO] = '{5, 7, 7};

  always #5 clk = ~clk;

  snn_inference_ctrl #(
    .NUM_INPUTS   (NI),
    .NUM_OUTPUTS  (NO),
    .COUNT_WIDTH  (CW),
    .STEP_WIDTH   (SW),
    .CLEAR_CYCLES (C),
    .DRAIN_CYCLES (D)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .start         (start),
    .abort         (abort),
    .num_steps     (num_steps),
    .pattern       (pattern),
    .spike_out     (spike_out),
    .spike_en      (spike_en),
    .net_clr       (net_clr),
    .busy          (busy),
    .done          (done),
    .spike_count   (spike_count),
    .winner        (winner),
    .saturated     (saturated)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_cnt"}, 64'(spike_count), 64'(exp_cnt));
    check({tag, "_win"}, 64'(winner), 64'(exp_win));
    check({tag, "_sat"}, 64'(saturated), 64'(exp_sat));
  endtask

  // Cycle k counts from the accept edge: CLEAR is k=1..C, RUN k=C+1..C+steps,
  // DRAIN up to C+steps+D, done at k=1+C+steps+D.
  task automatic run_inf(input int steps, input logic [NI-1:0] pat, input int mode,
                         input int abort_at, input int glitch_at);
    int            tot[NO];
    int            len;
    int            best;
    bit            ab;
    logic [NI-1:0] e_en;
    logic          e_clr, e_busy, e_done;
    logic [NO-1:0] sp;
    len = 1 + C + steps + D;
    foreach (tot[i]) tot[i] = 0;
    num_steps = SW'(steps);
    pattern   = pat;
    spike_out = NO'($urandom);
    start     = 1'b1;
    abort     = 1'b0;
    @(posedge clk); #1;
    start     = 1'b0;
    num_steps = SW'($urandom);
    pattern   = NI'($urandom);
    for (int k = 1; k <= len + 1; k++) begin
      ab     = (abort_at > 0) && (k > abort_at);
      e_en   = (!ab && k > C && k <= C + steps) ? pat : '0;
      e_clr  = !ab && k <= C;
      e_busy = !ab && k <= C + steps + D;
      e_done = !ab && k == len;
      if (e_done) begin
        exp_sat = 1'b0;
        best    = -1;
        for (int i = 0; i < NO; i++) begin
          int v;
          v = (tot[i] > 255) ? 255 : tot[i];
          if (tot[i] >= 255) exp_sat = 1'b1;
          exp_cnt[i*CW +: CW] = CW'(v);
          if (v > best) begin
            best    = v;
            exp_win = 2'(i);
          end
        end
      end
      check("ctl", 64'({spike_en, net_clr, busy, done}), 64'({e_en, e_clr, e_busy, e_done}));
      check_results("res");
      case (mode)
        0: sp = NO'($urandom);
        1: sp = '1;
        2: sp = '0;
        3: for (int i = 0; i < NO; i++) sp[i] = (k > C) && (tot[i] < tgt[i]);
        default: sp = NO'(1);
      endcase
      spike_out = sp;
      if (!ab && k > C && k <= C + steps + D)
        for (int i = 0; i < NO; i++) tot[i] += int'(sp[i]);
      abort = (k == abort_at);
      start = (k == glitch_at);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    abort     = 1'b0;
    spike_out = '0;
  endtask

  initial begin
    int steps;
    int ab_at;
    int gl_at;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 64'({spike_en, net_clr, busy, done}), 64'(0));
    check_results("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(busy), 64'(0));

    // single neuron firing constantly, 10 steps
    run_inf(10, 4'b1011, 4, 0, 0);
    check("t2_cnt0", 64'(spike_count[7:0]), 64'(14));
    check("t2_sat", 64'(saturated), 64'(0));

    // asynchronous reset in the middle of RUN
    num_steps = 16'd20;
    pattern   = 4'hF;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    exp_win = '0;
    exp_sat = 1'b0;
    check("midrst_ctl", 64'({spike_en, net_clr, busy, done}), 64'(0));
    check_results("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", 64'({spike_en, net_clr, busy, done}), 64'(0));
    @(posedge clk); #1;
    check("midrst_idle2", 64'(busy), 64'(0));

    run_inf(300, 4'b0110, 1, 0, 0);
    check("t3_cnt0", 64'(spike_count[7:0]), 64'(255));
    check("t3_sat", 64'(saturated), 64'(1));

    run_inf(0, 4'hF, 2, 0, 0);
    check("t4_cnt", 64'(spike_count), 64'(0));

    run_inf(9, 4'b1101, 0, 0, 0);
    run_inf(10, 4'b1011, 0, C + 3, 0);
    run_inf(6, 4'b0101, 0, 1, 0);
    run_inf(5, 4'b0011, 0, C + 5 + 2, 0);
    run_inf(6, 4'b1001, 0, 0, 4);

    run_inf(8, 4'b0111, 3, 0, 0);
    check("t6_pack", 64'(spike_count), 64'({8'd7, 8'd7, 8'd5}));
    check("t6_win", 64'(winner), 64'(1));

    // abort beats a simultaneous start in IDLE
    num_steps = 16'd5;
    start     = 1'b1;
    abort     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort", 64'({spike_en, net_clr, busy, done}), 64'(0));
    @(posedge clk); #1;
    check("idle_abort2", 64'(busy), 64'(0));

    for (int r = 0; r < 24; r++) begin
      steps = int'($urandom_range(0, 40));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, C + steps + D)) : 0;
      gl_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, C + steps + D + 1)) : 0;
      run_inf(steps, NI'($urandom), int'($urandom_range(0, 4)), ab_at, gl_at);
    end

    run_inf(65535, 4'b1010, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
